// File: rtl/bricks_drawer.sv
// Destructible brick-wall drawer: 20x15 tile map with init, hit and per-frame crumble sweep.
// state | meaning: S_INIT fills map from pattern; S_RUN accepts hits; S_SWEEP ages crumbling tiles
module bricks_drawer #(
  parameter int TILE_W         = 32,
  parameter int COLS           = 20,
  parameter int ROWS           = 15,
  parameter int CRUMBLE_FRAMES = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [10:0] pixel_x_i,
  input  logic [10:0] pixel_y_i,
  input  logic        start_of_frame_i,
  input  logic        hit_valid_i,
  input  logic [4:0]  hit_tile_x_i,
  input  logic [3:0]  hit_tile_y_i,
  output logic        hit_ready_o,
  output logic        walls_dr_o,
  output logic [7:0]  walls_rgb_o,
  output logic        destroyed_o,
  output logic [8:0]  bricks_remaining_o,
  output logic        init_done_o
);

  localparam int          CELLS    = COLS * ROWS;
  localparam logic [8:0]  LAST_IDX = 9'(CELLS - 1);
  localparam logic [4:0]  LAST_TX  = 5'(COLS - 1);
  localparam logic [3:0]  LAST_AGE = 4'(CRUMBLE_FRAMES + 1);
  localparam logic [10:0] X_VIS    = 11'(COLS * TILE_W);
  localparam logic [10:0] Y_VIS    = 11'(ROWS * TILE_W);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_SWEEP} state_t;

  state_t      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [4:0]  tx_q, tx_d;
  logic [3:0]  ty_q, ty_d;
  logic [8:0]  bricks_q, bricks_d;
  logic        init_done_q, init_done_d;
  logic        destroyed_q, destroyed_d;
  logic        walls_dr_q, walls_dr_d;
  logic [7:0]  walls_rgb_q, walls_rgb_d;

  logic [3:0]  map_q [CELLS];
  logic        we;
  logic [8:0]  waddr;
  logic [3:0]  wdata;

  logic [5:0]  tile_sum;
  logic        is_brick;
  logic        hit_in_range;
  logic [8:0]  hit_idx;
  logic [3:0]  hit_entry;
  logic [3:0]  sweep_entry;
  logic        draw_vis;
  logic [8:0]  draw_idx;
  logic [3:0]  draw_entry;

  assign tile_sum = 6'(tx_q) + 6'(ty_q);
  assign is_brick = !(tx_q[0] & ty_q[0]) && (tile_sum >= 6'd3) && ((tile_sum % 6'd3) != 6'd0);

  // Out-of-range requests are clamped to index 0 so the map is never read past its end.
  assign hit_in_range = (hit_tile_x_i < 5'(COLS)) && (hit_tile_y_i < 4'(ROWS));
  assign hit_idx      = hit_in_range ? (9'(hit_tile_y_i) * 9'(COLS) + 9'(hit_tile_x_i)) : 9'd0;
  assign hit_entry    = map_q[hit_idx];
  assign sweep_entry  = map_q[idx_q];

  assign draw_vis   = (pixel_x_i < X_VIS) && (pixel_y_i < Y_VIS);
  assign draw_idx   = draw_vis ? (9'(pixel_y_i[8:5]) * 9'(COLS) + 9'(pixel_x_i[9:5])) : 9'd0;
  assign draw_entry = map_q[draw_idx];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    bricks_d    = bricks_q;
    init_done_d = init_done_q;
    destroyed_d = 1'b0;
    we          = 1'b0;
    waddr       = idx_q;
    wdata       = 4'd0;
    hit_ready_o = 1'b0;
    case (state_q)
      S_INIT: begin
        we    = 1'b1;
        wdata = is_brick ? 4'd1 : 4'd0;
        if (is_brick) bricks_d = bricks_q + 9'd1;
        idx_d = idx_q + 9'd1;
        if (tx_q == LAST_TX) begin
          tx_d = 5'd0;
          ty_d = ty_q + 4'd1;
        end else begin
          tx_d = tx_q + 5'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
          idx_d       = 9'd0;
          tx_d        = 5'd0;
          ty_d        = 4'd0;
        end
      end
      S_RUN: begin
        hit_ready_o = 1'b1;
        if (hit_valid_i && hit_in_range && (hit_entry == 4'd1)) begin
          we          = 1'b1;
          waddr       = hit_idx;
          wdata       = 4'd2;
          destroyed_d = 1'b1;
          bricks_d    = bricks_q - 9'd1;
        end
        if (start_of_frame_i) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        we = 1'b1;
        if (sweep_entry <= 4'd1) wdata = sweep_entry;
        else if (sweep_entry >= LAST_AGE) wdata = 4'd0;
        else wdata = sweep_entry + 4'd1;
        idx_d = idx_q + 9'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_RUN;
          idx_d   = 9'd0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    walls_dr_d  = 1'b0;
    walls_rgb_d = 8'h00;
    if (state_q != S_INIT && draw_vis && draw_entry != 4'd0) begin
      walls_dr_d = 1'b1;
      if (draw_entry == 4'd1)
        walls_rgb_d = (pixel_x_i[4:0] == 5'd0 || pixel_y_i[4:0] == 5'd0) ? 8'h92 : 8'hB6;
      else
        walls_rgb_d = draw_entry[0] ? 8'hFC : 8'hE0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_INIT;
      idx_q       <= 9'd0;
      tx_q        <= 5'd0;
      ty_q        <= 4'd0;
      bricks_q    <= 9'd0;
      init_done_q <= 1'b0;
      destroyed_q <= 1'b0;
      walls_dr_q  <= 1'b0;
      walls_rgb_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      bricks_q    <= bricks_d;
      init_done_q <= init_done_d;
      destroyed_q <= destroyed_d;
      walls_dr_q  <= walls_dr_d;
      walls_rgb_q <= walls_rgb_d;
    end
  end

  // Map contents need no reset: INIT rewrites every entry before drawing is enabled.
  always_ff @(posedge clk_i) begin
    if (we) map_q[waddr] <= wdata;
  end

  assign walls_dr_o         = walls_dr_q;
  assign walls_rgb_o        = walls_rgb_q;
  assign destroyed_o        = destroyed_q;
  assign bricks_remaining_o = bricks_q;
  assign init_done_o        = init_done_q;

endmodule

// File: tb/tb_bricks_drawer.sv
// Directed bench for bricks_drawer: init pattern, drawing, hits, crumble sweeps and reset.
module tb_bricks_drawer;

  logic        clk;
  logic        reset;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        sof;
  logic        hit_valid;
  logic [4:0]  hit_tx;
  logic [3:0]  hit_ty;
  logic        hit_ready;
  logic        walls_dr;
  logic [7:0]  walls_rgb;
  logic        destroyed;
  logic [8:0]  bricks;
  logic        init_done;

  int checks   = 0;
  int failures = 0;
  int exp_bricks;
  int full_count;
  int wait_cnt;

  bricks_drawer dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .pixel_x_i          (pixel_x),
    .pixel_y_i          (pixel_y),
    .start_of_frame_i   (sof),
    .hit_valid_i        (hit_valid),
    .hit_tile_x_i       (hit_tx),
    .hit_tile_y_i       (hit_ty),
    .hit_ready_o        (hit_ready),
    .walls_dr_o         (walls_dr),
    .walls_rgb_o        (walls_rgb),
    .destroyed_o        (destroyed),
    .bricks_remaining_o (bricks),
    .init_done_o        (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rule_count();
    int n = 0;
    for (int ty = 0; ty < 15; ty++)
      for (int tx = 0; tx < 20; tx++)
        if (!((tx % 2 == 1) && (ty % 2 == 1)) && (tx + ty >= 3) && ((tx + ty) % 3 != 0))
          n++;
    return n;
  endfunction

  task automatic probe(input int x, input int y);
    @(negedge clk);
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic do_hit(input int tx, input int ty, input int exp_pulse, input string tag);
    @(negedge clk);
    hit_valid = 1'b1;
    hit_tx    = 5'(tx);
    hit_ty    = 4'(ty);
    @(posedge clk);
    #1;
    check({tag, "_destroyed"}, int'(destroyed), exp_pulse);
    check({tag, "_bricks"}, int'(bricks), exp_bricks);
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  task automatic frame_sweep();
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    repeat (302) @(posedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    pixel_x   = '0;
    pixel_y   = '0;
    sof       = 1'b0;
    hit_valid = 1'b0;
    hit_tx    = '0;
    hit_ty    = '0;
    full_count = rule_count();

    @(posedge clk);
    #1;
    check("rst_dr", int'(walls_dr), 0);
    check("rst_rgb", int'(walls_rgb), 0);
    check("rst_ready", int'(hit_ready), 0);
    check("rst_destroyed", int'(destroyed), 0);
    check("rst_bricks", int'(bricks), 0);
    check("rst_init_done", int'(init_done), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (299) @(posedge clk);
    #1;
    check("init_done_299", int'(init_done), 0);
    check("init_ready_299", int'(hit_ready), 0);
    @(posedge clk);
    #1;
    check("init_done_300", int'(init_done), 1);
    check("init_bricks", int'(bricks), full_count);
    check("run_ready", int'(hit_ready), 1);
    exp_bricks = full_count;

    probe(129, 1);
    check("px_4_0_dr", int'(walls_dr), 1);
    check("px_4_0_rgb", int'(walls_rgb), 'hB6);
    probe(128, 5);
    check("px_mortar_rgb", int'(walls_rgb), 'h92);
    probe(700, 10);
    check("px_offscreen_dr", int'(walls_dr), 0);
    check("px_offscreen_rgb", int'(walls_rgb), 0);
    probe(5, 5);
    check("px_0_0_dr", int'(walls_dr), 0);
    probe(101, 37);
    check("px_3_1_dr", int'(walls_dr), 0);
    probe(69, 37);
    check("px_2_1_dr", int'(walls_dr), 0);

    exp_bricks = full_count - 1;
    do_hit(4, 0, 1, "hit_4_0");
    @(posedge clk);
    #1;
    check("hit_pulse_once", int'(destroyed), 0);
    probe(129, 1);
    check("crumble2_dr", int'(walls_dr), 1);
    check("crumble2_rgb", int'(walls_rgb), 'hE0);

    do_hit(0, 0, 0, "hit_empty");
    do_hit(25, 3, 0, "hit_range");
    do_hit(4, 0, 0, "hit_again");

    frame_sweep();
    probe(129, 1);
    check("crumble3_rgb", int'(walls_rgb), 'hFC);
    for (int f = 1; f < 8; f++) frame_sweep();
    probe(129, 1);
    check("crumble_gone_dr", int'(walls_dr), 0);
    check("crumble_gone_rgb", int'(walls_rgb), 0);
    check("crumble_bricks", int'(bricks), exp_bricks);

    // start of frame together with a hit, then a second hit held across the sweep
    @(negedge clk);
    sof       = 1'b1;
    hit_valid = 1'b1;
    hit_tx    = 5'd6;
    hit_ty    = 4'd1;
    @(posedge clk);
    #1;
    exp_bricks = exp_bricks - 1;
    check("sof_hit_destroyed", int'(destroyed), 1);
    check("sof_hit_bricks", int'(bricks), exp_bricks);
    check("sweep_ready", int'(hit_ready), 0);
    @(negedge clk);
    sof    = 1'b0;
    hit_tx = 5'd8;
    hit_ty = 4'd0;
    wait_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      wait_cnt++;
      if (hit_ready) break;
    end
    check("sweep_ready_low_cycles", wait_cnt, 300);
    check("held_not_yet", int'(destroyed), 0);
    @(posedge clk);
    #1;
    exp_bricks = exp_bricks - 1;
    check("held_destroyed", int'(destroyed), 1);
    check("held_bricks", int'(bricks), exp_bricks);
    @(negedge clk);
    hit_valid = 1'b0;
    probe(197, 37);
    check("sof_hit_aged_rgb", int'(walls_rgb), 'hFC);
    probe(261, 5);
    check("held_tile_rgb", int'(walls_rgb), 'hE0);

    // reset in the middle of a sweep
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_dr", int'(walls_dr), 0);
    check("rst2_rgb", int'(walls_rgb), 0);
    check("rst2_ready", int'(hit_ready), 0);
    check("rst2_bricks", int'(bricks), 0);
    check("rst2_init_done", int'(init_done), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("reinit_done", int'(init_done), 1);
    check("reinit_bricks", int'(bricks), full_count);
    probe(129, 1);
    check("reinit_4_0_rgb", int'(walls_rgb), 'hB6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bricks_drawer.md
# bricks_drawer

Object drawer for the destructible brick walls of the Bomberman playfield. It holds a 20x15 tile map of brick states, answers per-pixel drawing requests as the producer of the wall drawing-request/RGB pair consumed by the column/wall priority mux, and accepts tile-destroy requests from the explosion logic. Destroyed bricks crumble for 8 frames before disappearing.

## Interface
- TILE_W, 32, tile width and height in pixels (fixed power of two; the index math uses bits [9:5] and [8:5])
- COLS, 20, tiles per row
- ROWS, 15, tile rows
- CRUMBLE_FRAMES, 8, frames a destroyed brick stays visible

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixelX  in  11  current pixel column, 0..639 visible
- pixelY  in  11  current pixel row, 0..479 visible
- startOfFrame  in  1  one-cycle pulse at the start of vertical blanking
- hitValid  in  1  destroy request valid
- hitTileX  in  5  requested tile column
- hitTileY  in  4  requested tile row
- hitReady  out  1  request accepted when hitValid && hitReady
- wallsDR  out  1  brick pixel present
- wallsRGB  out  8  RGB332 pixel colour
- destroyed  out  1  one-cycle pulse: an intact brick was destroyed
- bricksRemaining  out  9  count of intact bricks
- initDone  out  1  map initialisation complete

## Operation
- Map: 300 entries of 4 bits. The index is ty*20+tx. Values: 0 = empty, 1 = brick, 2..9 = crumbling age.
- FSM states: INIT, RUN, SWEEP.
- INIT (entered on reset):
  - Walks index 0..299, one entry per cycle.
  - Writes 1 where the tile is not a column (!(tx[0]&ty[0])), tx+ty >= 3, and (tx+ty) mod 3 != 0. Writes 0 everywhere else.
  - Increments bricksRemaining for each brick written.
  - After index 299 it sets initDone=1 and goes to RUN.
  - hitReady=0 and wallsDR=0 throughout.
- RUN:
  - hitReady=1.
  - On an accepted hit with tx<20 and ty<15 and entry==1: entry becomes 2, destroyed pulses, and bricksRemaining decrements.
  - Any other accepted hit (out of range, empty, crumbling) has no effect and raises no pulse.
  - startOfFrame moves the FSM to SWEEP on the next cycle.
- SWEEP:
  - hitReady=0. Walks index 0..299, one per cycle.
  - An entry of 2..8 becomes entry+1. An entry of 9 becomes 0. Entries 0 and 1 are unchanged.
  - Returns to RUN after index 299, taking 300 cycles, which fits inside vertical blanking.
- startOfFrame during INIT or SWEEP is ignored.
- Drawing (a separate read port, active in RUN and SWEEP):
  - A pixel inside 640x480 reads entry [pixelY[8:5]*20 + pixelX[9:5]].
  - Entry 1: DR=1. RGB=8'h92 if local x==0 or local y==0 (mortar), else 8'hB6.
  - Entry 2..9: DR=1. RGB=8'hE0 if the age is even, else 8'hFC (flicker).
  - Entry 0, or a pixel outside the visible area: DR=0, RGB=8'h00.

## Timing
- Reset values: wallsDR=0, wallsRGB=0, hitReady=0, destroyed=0, bricksRemaining=0, initDone=0, state INIT, index 0.
- Reset asserted mid-operation aborts the current state and restarts INIT.
- The pixel path is registered:
  - wallsDR and wallsRGB reflect the pixelX/pixelY presented one cycle earlier.
  - Map writes become visible to the draw read on the cycle after the write edge.
- Hit path:
  - The map write, destroyed pulse and bricksRemaining update all occur on the clock edge that accepts the request.
  - One request per cycle.
- hitReady is combinational from the state: 1 only in RUN.
- startOfFrame and an accepted hit in the same RUN cycle: the hit is applied and SWEEP starts the next cycle. That brick is then aged 2→3 in the same sweep.
- The hit requester must hold hitValid and the tile while hitReady=0. No request is dropped.
- INIT takes 300 cycles after reset deasserts. initDone rises on cycle 300 and stays high until reset.

## Test plan
- Reset for 2 cycles, then wait 300 cycles. Required:
  - initDone rises exactly at cycle 300.
  - bricksRemaining equals the rule count computed by the bench.
  - Tile (4,0) reads 1; tiles (0,0), (3,1) and (2,1) read 0.
- Pixel (129,1), i.e. tile (4,0): wallsDR=1 and wallsRGB=8'hB6 one cycle later. Pixel (128,5): RGB=8'h92. Pixel (700,10): wallsDR=0.
- Hit tile (4,0) in RUN:
  - destroyed pulses once and bricksRemaining decrements by 1.
  - The pixel at (129,1) shows 8'hE0.
  - After 8 startOfFrame pulses, each followed by 300 idle cycles, wallsDR=0 at that pixel.
- Hits to (0,0), to (25,3), and a second hit to (4,0) while crumbling: no destroyed pulse and bricksRemaining unchanged.
- startOfFrame coincident with a hit to (6,1): the hit is applied, hitReady stays low for 300 cycles, and a hit held during that time is accepted on the first RUN cycle.
- Assert reset during SWEEP: all outputs return to 0 and INIT reruns to the original brick count.
